// File: rtl/da_tx_pkg.sv
// Shared definitions for the forwarded-clock data transmitter.
// State encoding, default lane words and a saturating counter helper.
package da_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESYNC = 2'd1,
        ST_TRAIN  = 2'd2,
        ST_DATA   = 2'd3
    } state_e;

    localparam logic [7:0] DEF_CLK_WORD   = 8'hAA;
    localparam logic [7:0] DEF_TRAIN_WORD = 8'h55;
    localparam logic [7:0] DEF_IDLE_WORD  = 8'h00;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/da_tx_fifo2.sv
// Two-entry FIFO with count output and synchronous flush.
// A push while full is dropped; the producer is expected to honour count.
module da_tx_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_in,
    input  logic         push_in,
    input  logic [W-1:0] din_in,
    input  logic         pop_in,
    output logic [W-1:0] dout_out,
    output logic [1:0]   count_out
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push_ok;
    logic         pop_ok;

    // Pointer and count update; flush wins over any push or pop.
    always_comb begin
        push_ok = push_in && (cnt_q != 2'd2);
        pop_ok  = pop_in && (cnt_q != 2'd0);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (flush_in) begin
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = din_in;
                wr_d        = ~wr_q;
            end
            if (pop_ok) begin
                rd_d = ~rd_q;
            end
            cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout_out  = mem_q[rd_q];
    assign count_out = cnt_q;

endmodule

// File: rtl/da_clk_data_tx.sv
// Forwarded-clock source-synchronous transmitter front end.
// Sequences resync, lane training and buffered data onto serializer words.
module da_clk_data_tx
    import da_tx_pkg::*;
#(
    parameter int         LANES      = 4,
    parameter int         RESYNC_LEN = 16,
    parameter int         TRAIN_LEN  = 512,
    parameter logic [7:0] CLK_WORD   = DEF_CLK_WORD,
    parameter logic [7:0] TRAIN_WORD = DEF_TRAIN_WORD,
    parameter logic [7:0] IDLE_WORD  = DEF_IDLE_WORD
) (
    input  logic               clk_div_in,
    input  logic               rst_n_in,
    input  logic               tx_en_in,
    input  logic               train_req_in,
    input  logic [8*LANES-1:0] s_data_in,
    input  logic               s_valid_in,
    output logic               s_ready_out,
    output logic [7:0]         clk_word_out,
    output logic [8*LANES-1:0] data_word_out,
    output logic               re_sync_out,
    output logic [1:0]         state_out,
    output logic               train_done_out,
    output logic [15:0]        underflow_cnt_out
);

    localparam int          DW      = 8 * LANES;
    localparam logic [15:0] RS_LAST = 16'(RESYNC_LEN - 1);
    localparam logic [15:0] TR_LAST = 16'(TRAIN_LEN - 1);

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            treq_q;
    logic            train_edge;

    logic [7:0]      clk_word_q, clk_word_d;
    logic [DW-1:0]   data_q, data_d;
    logic            re_sync_q, re_sync_d;
    logic            done_q, done_d;
    logic [15:0]     unf_q, unf_d;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;
    logic [DW-1:0]   fifo_dout;
    logic [1:0]      fifo_cnt;
    logic            in_data;

    assign train_edge = train_req_in && !treq_q;

    // State, phase counter and train request delay registers.
    always_ff @(posedge clk_div_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            treq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            treq_q  <= train_req_in;
        end
    end

    // Next state; disabling the transmitter overrides everything else.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!tx_en_in) begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_RESYNC;
                    cnt_d   = 16'd0;
                end
                ST_RESYNC: begin
                    if (train_edge) begin
                        cnt_d = 16'd0;
                    end else if (cnt_q == RS_LAST) begin
                        state_d = ST_TRAIN;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_TRAIN: begin
                    if (train_edge) begin
                        state_d = ST_RESYNC;
                        cnt_d   = 16'd0;
                    end else if (cnt_q == TR_LAST) begin
                        state_d = ST_DATA;
                        cnt_d   = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (train_edge) begin
                        state_d = ST_RESYNC;
                        cnt_d   = 16'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end
            endcase
        end
    end

    // Output words follow the next state so they line up with state_out.
    // A word being written this cycle is in flight, not a starved cycle.
    always_comb begin
        in_data    = (state_q == ST_DATA) && (state_d == ST_DATA);
        fifo_push  = s_valid_in && s_ready_out;
        fifo_pop   = in_data && (fifo_cnt != 2'd0);
        fifo_flush = (state_q == ST_DATA) && (state_d != ST_DATA);
        clk_word_d = (state_d == ST_IDLE) ? 8'h00 : CLK_WORD;
        re_sync_d  = (state_d == ST_RESYNC);
        done_d     = (state_q == ST_TRAIN) && (state_d == ST_DATA);
        data_d     = {LANES{IDLE_WORD}};
        unf_d      = unf_q;
        unique case (state_d)
            ST_IDLE:   data_d = {LANES{IDLE_WORD}};
            ST_RESYNC: begin
                data_d = {LANES{IDLE_WORD}};
                unf_d  = 16'd0;
            end
            ST_TRAIN:  data_d = {LANES{TRAIN_WORD}};
            ST_DATA: begin
                if (fifo_pop) begin
                    data_d = fifo_dout;
                end else if (in_data && !fifo_push) begin
                    unf_d = sat_inc16(unf_q);
                end
            end
            default:   data_d = {LANES{IDLE_WORD}};
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk_div_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            clk_word_q <= 8'h00;
            data_q     <= {LANES{IDLE_WORD}};
            re_sync_q  <= 1'b0;
            done_q     <= 1'b0;
            unf_q      <= 16'd0;
        end else begin
            clk_word_q <= clk_word_d;
            data_q     <= data_d;
            re_sync_q  <= re_sync_d;
            done_q     <= done_d;
            unf_q      <= unf_d;
        end
    end

    da_tx_fifo2 #(
        .W (DW)
    ) u_fifo (
        .clk       (clk_div_in),
        .rst_n     (rst_n_in),
        .flush_in  (fifo_flush),
        .push_in   (fifo_push),
        .din_in    (s_data_in),
        .pop_in    (fifo_pop),
        .dout_out  (fifo_dout),
        .count_out (fifo_cnt)
    );

    assign s_ready_out       = (state_q == ST_DATA) && (fifo_cnt != 2'd2);
    assign clk_word_out      = clk_word_q;
    assign data_word_out     = data_q;
    assign re_sync_out       = re_sync_q;
    assign state_out         = state_q;
    assign train_done_out    = done_q;
    assign underflow_cnt_out = unf_q;

endmodule

// File: tb/tb_da_clk_data_tx.sv
// Self-checking bench for da_clk_data_tx at default parameters.
// A queue-based reference model predicts the data path.
module tb_da_clk_data_tx;

    localparam int          RS    = 16;
    localparam int          TR    = 512;
    localparam logic [31:0] TPAT  = 32'h55555555;
    localparam logic [31:0] IPAT  = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_en;
    logic        train_req;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  clk_word;
    logic [31:0] data_word;
    logic        re_sync;
    logic [1:0]  state;
    logic        done;
    logic [15:0] unf;

    int n_chk = 0;
    int n_fail = 0;

    da_clk_data_tx dut (
        .clk_div_in        (clk),
        .rst_n_in          (rst_n),
        .tx_en_in          (tx_en),
        .train_req_in      (train_req),
        .s_data_in         (s_data),
        .s_valid_in        (s_valid),
        .s_ready_out       (s_ready),
        .clk_word_out      (clk_word),
        .data_word_out     (data_word),
        .re_sync_out       (re_sync),
        .state_out         (state),
        .train_done_out    (done),
        .underflow_cnt_out (unf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tx_en = 1'b0;
        train_req = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        step();
        step();
        n_chk++;
        if (state !== 2'd0 || clk_word !== 8'h00 || data_word !== IPAT) begin
            n_fail++;
            $display("FAIL reset_words: state=%0d clk=%h data=%h want 0/00/0",
                     state, clk_word, data_word);
        end
        n_chk++;
        if (re_sync !== 1'b0 || done !== 1'b0 || unf !== 16'd0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: rs=%b done=%b unf=%0d rdy=%b want 0",
                     re_sync, done, unf, s_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    // Enable and walk RESYNC/TRAIN up to DATA; optional train edge after
    // k RESYNC cycles; rs0 counts RESYNC cycles already observed.
    task automatic run_train(input int k, input int rs0, input string nm);
        int rs = rs0;
        int tc = 0;
        int tbad = 0;
        int cbad = 0;
        int dn = 0;
        bit fired = 0;
        bit reached = 0;
        tx_en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (re_sync) rs++;
            if (re_sync !== (state == 2'd1)) cbad++;
            if (state != 2'd0 && clk_word !== 8'hAA) cbad++;
            if (state == 2'd2) begin
                if (data_word === TPAT) tc++;
                else tbad++;
            end
            if (done) dn++;
            if (k != 0 && !fired && rs == k) begin
                train_req = 1'b1;
                fired = 1;
            end
            if (fired && state == 2'd2) train_req = 1'b0;
            if (state == 2'd3) begin
                reached = 1;
                break;
            end
        end
        n_chk++;
        if (!reached) begin
            n_fail++;
            $display("FAIL %s_timeout: state=%0d want 3", nm, state);
        end
        n_chk++;
        if (rs != k + RS) begin
            n_fail++;
            $display("FAIL %s_resync_len: got %0d want %0d", nm, rs, k + RS);
        end
        n_chk++;
        if (tc != TR || tbad != 0) begin
            n_fail++;
            $display("FAIL %s_train_len: got %0d bad %0d want %0d", nm, tc, tbad, TR);
        end
        n_chk++;
        if (dn != 1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done: pulses %0d now %b want 1/1", nm, dn, done);
        end
        n_chk++;
        if (cbad != 0) begin
            n_fail++;
            $display("FAIL %s_clk_rs: %0d bad cycles want 0", nm, cbad);
        end
        n_chk++;
        if (data_word !== IPAT || unf !== 16'd0) begin
            n_fail++;
            $display("FAIL %s_entry: data=%h unf=%0d want 0/0", nm, data_word, unf);
        end
    endtask

    task automatic test_train();
        run_train(5, 0, "train");
    endtask

    // Counting stream, drain plus ten starved cycles, then random traffic.
    task automatic test_data_path();
        logic [31:0] q[$];
        logic [31:0] exp;
        int m_unf = 0;
        int bad = 0;
        int ntot = 16 + 11 + 300;
        bit v;
        logic [31:0] d;
        bit rdy;
        for (int i = 0; i < ntot; i++) begin
            if (i < 16) begin
                v = 1;
                d = 32'(i + 1);
            end else if (i < 27) begin
                v = 0;
                d = $urandom;
            end else begin
                v = ($urandom_range(0, 2) != 0);
                d = $urandom;
            end
            s_valid = v;
            s_data = d;
            #1;
            rdy = (q.size() < 2);
            n_chk++;
            if (s_ready !== rdy) begin
                n_fail++;
                $display("FAIL ready_%0d: got %b want %b", i, s_ready, rdy);
            end
            step();
            if (q.size() > 0) begin
                exp = q.pop_front();
            end else begin
                exp = IPAT;
                if (!v && m_unf < 65535) m_unf++;
            end
            if (v && rdy) q.push_back(d);
            n_chk++;
            if (data_word !== exp || unf !== 16'(m_unf) || done !== 1'b0 || state !== 2'd3) begin
                n_fail++;
                bad++;
                $display("FAIL data_%0d: data=%h unf=%0d done=%b st=%0d want %h/%0d/0/3",
                         i, data_word, unf, done, state, exp, m_unf);
            end
            if (i == 15) begin
                n_chk++;
                if (data_word !== 32'h0000000F || unf !== 16'd0) begin
                    n_fail++;
                    $display("FAIL stream_end: data=%h unf=%0d want 0000000f/0",
                             data_word, unf);
                end
            end
            if (i == 26) begin
                n_chk++;
                if (data_word !== IPAT || unf !== 16'd10) begin
                    n_fail++;
                    $display("FAIL starve10: data=%h unf=%0d want 0/10", data_word, unf);
                end
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_retrain();
        s_valid = 1'b1;
        s_data = $urandom;
        step();
        train_req = 1'b1;
        step();
        s_valid = 1'b0;
        #1;
        n_chk++;
        if (state !== 2'd1 || s_ready !== 1'b0 || re_sync !== 1'b1) begin
            n_fail++;
            $display("FAIL retrain_enter: st=%0d rdy=%b rs=%b want 1/0/1",
                     state, s_ready, re_sync);
        end
        n_chk++;
        if (unf !== 16'd0 || data_word !== IPAT) begin
            n_fail++;
            $display("FAIL retrain_clear: unf=%0d data=%h want 0/0", unf, data_word);
        end
        run_train(0, 1, "retrain");
        step();
        n_chk++;
        if (data_word !== IPAT || unf !== 16'd1) begin
            n_fail++;
            $display("FAIL retrain_flush: data=%h unf=%0d want 0/1", data_word, unf);
        end
        train_req = 1'b0;
    endtask

    task automatic test_tx_off();
        tx_en = 1'b0;
        step();
        n_chk++;
        if (state !== 2'd0 || clk_word !== 8'h00) begin
            n_fail++;
            $display("FAIL off_data: st=%0d clk=%h want 0/00", state, clk_word);
        end
        tx_en = 1'b1;
        for (int i = 0; i < 1 + RS + 20; i++) step();
        n_chk++;
        if (state !== 2'd2 || data_word !== TPAT) begin
            n_fail++;
            $display("FAIL off_pre: st=%0d data=%h want 2/55555555", state, data_word);
        end
        tx_en = 1'b0;
        step();
        n_chk++;
        if (state !== 2'd0 || clk_word !== 8'h00 || data_word !== IPAT || re_sync !== 1'b0) begin
            n_fail++;
            $display("FAIL off_train: st=%0d clk=%h data=%h rs=%b want 0/00/0/0",
                     state, clk_word, data_word, re_sync);
        end
    endtask

    task automatic test_async_reset();
        run_train(0, 0, "pre_rst");
        s_valid = 1'b1;
        s_data = 32'hDEADBEEF;
        step();
        s_data = 32'hCAFEF00D;
        step();
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (state !== 2'd0 || clk_word !== 8'h00 || data_word !== IPAT || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: st=%0d clk=%h data=%h rdy=%b want 0/00/0/0",
                     state, clk_word, data_word, s_ready);
        end
        n_chk++;
        if (re_sync !== 1'b0 || done !== 1'b0 || unf !== 16'd0) begin
            n_fail++;
            $display("FAIL async_rst_flags: rs=%b done=%b unf=%0d want 0",
                     re_sync, done, unf);
        end
        tx_en = 1'b0;
        train_req = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        run_train(0, 0, "post_rst");
        step();
        n_chk++;
        if (data_word !== IPAT) begin
            n_fail++;
            $display("FAIL rst_discard: data=%h want 0", data_word);
        end
        train_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_train();
        test_data_path();
        test_retrain();
        test_tx_off();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/da_clk_data_tx.md
DA_CLK_DATA_TX -- requirements
Module: da_clk_data_tx

Interface
REQ-001 SHALL have parameter LANES, default 4, number of 8-bit data lanes.
REQ-002 SHALL have parameter RESYNC_LEN, default 16, re_sync_out pulse length in cycles (range 1-255).
REQ-003 SHALL have parameter TRAIN_LEN, default 512, training words per lane (range 1-65535).
REQ-004 SHALL have parameter CLK_WORD, default 8'hAA, forwarded-clock serializer word.
REQ-005 SHALL have parameter TRAIN_WORD, default 8'h55, data-lane training word.
REQ-006 SHALL have parameter IDLE_WORD, default 8'h00, data-lane filler word.
REQ-007 clk_div_in  input  1  divided serializer clock; the block's one clock, all logic on its rising edge.
REQ-008 rst_n_in  input  1  asynchronous, active-low reset.
REQ-009 tx_en_in  input  1  level; enables transmission.
REQ-010 train_req_in  input  1  level; its rising edge requests retraining.
REQ-011 s_data_in  input  8*LANES  parallel word; lane k is bits [8k+7:8k].
REQ-012 s_valid_in  input  1  s_data_in valid.
REQ-013 s_ready_out  output  1  block accepts s_data_in this cycle.
REQ-014 clk_word_out  output  8  word for the clock-lane serializer.
REQ-015 data_word_out  output  8*LANES  words for the data-lane serializers.
REQ-016 re_sync_out  output  1  receiver realignment request.
REQ-017 state_out  output  2  current state code.
REQ-018 train_done_out  output  1  one-cycle pulse at TRAIN->DATA.
REQ-019 underflow_cnt_out  output  16  saturating count of DATA cycles with no word available.

Function
REQ-020 States SHALL be IDLE=0, RESYNC=1, TRAIN=2, DATA=3; state_out SHALL equal the registered state.
REQ-021 IDLE->RESYNC SHALL occur when tx_en_in=1.
REQ-022 RESYNC->TRAIN SHALL occur after RESYNC_LEN cycles in RESYNC.
REQ-023 TRAIN->DATA SHALL occur after TRAIN_LEN cycles in TRAIN.
REQ-024 DATA->RESYNC SHALL occur on a detected train_req_in rising edge; the edge detector SHALL be a one-register delay.
REQ-025 tx_en_in=0 SHALL force IDLE on the next edge from any state, with priority over all other transitions.
REQ-026 A train_req_in edge in RESYNC or TRAIN SHALL restart RESYNC, reloading its counter.
REQ-027 clk_word_out SHALL be CLK_WORD in every state except IDLE, where it SHALL be 8'h00.
REQ-028 re_sync_out SHALL be 1 exactly while state is RESYNC.
REQ-029 data_word_out SHALL be IDLE_WORD on all lanes in IDLE and RESYNC, and TRAIN_WORD on all lanes in TRAIN.
REQ-030 A 2-entry FIFO SHALL buffer input words; a word SHALL be pushed when s_valid_in and s_ready_out are both 1.
REQ-031 s_ready_out SHALL be 1 only in DATA with FIFO count below 2.
REQ-032 In DATA, each cycle SHALL pop one word into the data_word_out register if the FIFO is non-empty; otherwise it SHALL load IDLE_WORD and increment underflow_cnt_out, saturating at 16'hFFFF.
REQ-033 A word pushed at edge N SHALL appear on data_word_out after edge N+1 when the FIFO was empty; FIFO order SHALL be preserved.
REQ-034 A push and a pop in the same cycle SHALL leave the FIFO count unchanged.
REQ-035 The FIFO SHALL flush on any transition out of DATA.
REQ-036 underflow_cnt_out SHALL clear on entry to RESYNC.
REQ-037 All outputs SHALL be registered, except s_ready_out, which SHALL be combinational from state and FIFO count.

Reset
REQ-038 On rst_n_in=0: state IDLE, FIFO empty, all counters 0, clk_word_out 8'h00, data_word_out all IDLE_WORD, re_sync_out 0, train_done_out 0, underflow_cnt_out 0, edge-detector register 0.
REQ-039 Reset asserted mid-operation SHALL take effect immediately (asynchronously), discarding buffered words.
REQ-040 Release SHALL not generate a spurious train_req edge.

Structure
REQ-041 Package da_tx_pkg SHALL hold the state encoding and the default CLK_WORD, TRAIN_WORD and IDLE_WORD constants.
REQ-042 The FIFO SHALL be sub-module da_tx_fifo2, with parameterized width, count output, and synchronous flush.

Verification
REQ-043 Reset, then tx_en_in=1 -> re_sync_out=1 for exactly 16 cycles, then 512 cycles of data_word_out=32'h55555555, train_done_out pulse, state_out=3, clk_word_out=8'hAA throughout.
REQ-044 In DATA, stream 32'h00000001..32'h00000010 with s_valid_in=1 continuously -> identical sequence on data_word_out, first word one edge after its push, underflow_cnt_out=0.
REQ-045 In DATA, s_valid_in=0 for 10 cycles -> data_word_out=32'h00000000 and underflow_cnt_out=10.
REQ-046 train_req_in 0->1 in DATA with FIFO holding 2 words -> next state RESYNC, s_ready_out=0, FIFO flushed, underflow_cnt_out cleared, pattern of REQ-043 repeats.
REQ-047 tx_en_in=0 mid-TRAIN -> state_out=0 and clk_word_out=8'h00 next cycle.
REQ-048 rst_n_in=0 mid-DATA -> all outputs at reset values without waiting for a clock edge.
